video_mode_sequencer: RTL
=========================

Name: video_mode_sequencer

Overview:
- Controller ahead of composite_video_encoder. Owns the encoder's register-write port (the debug-bus write signals) and the video_standard / secam_enabled inputs.
- On a standard-change request it waits for a frame boundary, then replays a per-standard preset write sequence into the encoder's registers. It then commits the new standard atomically.
- Host register writes share the same port. The sequencer has priority; a colliding host write is buffered and replayed afterwards.

Parameters:
- SEQ_GAP, 0, idle cycles inserted between consecutive preset writes (0 = back-to-back).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- newframe  in  1  one-cycle frame-start strobe from sync generator
- req_valid  in  1  standard-change request strobe
- req_standard  in  video_standard_e  requested standard
- host_addr  in  16  host write address
- host_wdata  in  8  host write data
- host_we  in  1  host write strobe
- bus_addr  out  16  encoder register write address
- bus_wdata  out  8  encoder register write data
- bus_we  out  1  encoder register write strobe
- video_standard  out  video_standard_e  committed standard
- secam_enabled  out  1  high when committed standard == SECAM
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on commit
- host_drop  out  1  sticky: a host write was lost; cleared only by reset

Behaviour:
- All outputs are registered.
- Reset values: bus_we=0, bus_addr=0, bus_wdata=0, video_standard=PAL, secam_enabled=0, busy=1, done=0, host_drop=0. No request is pending and the host buffer is empty.
- Reset state is BOOT. BOOT runs the PAL preset immediately, with no frame wait, then goes through COMMIT to IDLE.
- Reset asserted mid-sequence aborts the sequence, discards any pending request and the buffered host write, and restarts BOOT.
- States:
  - IDLE: waiting for a request.
  - WAIT_FRAME: waiting for newframe.
  - WRITE: issuing preset writes.
  - FLUSH: replaying the buffered host write.
  - COMMIT: updating the committed standard.
- Request handling:
  - IDLE with req_valid and req_standard != video_standard → WAIT_FRAME, target latched.
  - req_standard == video_standard in IDLE is ignored: no writes, no done.
  - req_valid in any non-IDLE state stores a pending request (last wins). The pending request is evaluated on the first IDLE cycle as if it had just been presented.
- WAIT_FRAME: newframe → WRITE on the next cycle. A new req_valid here replaces the target.
- WRITE:
  - Index counter 0..N-1 walks the preset table of the target standard.
  - Each entry produces bus_we=1 for one cycle, followed by SEQ_GAP cycles of bus_we=0.
  - After entry N-1: go to FLUSH if the buffer is occupied, else COMMIT.
- FLUSH: emits the buffered write in one cycle, then goes to COMMIT.
- COMMIT (one cycle): video_standard ← target, secam_enabled ← (target==SECAM), done=1, then → IDLE.
- The first preset write appears on the bus 2 cycles after newframe.
- Host arbitration:
  - When the sequencer is not driving the bus in a cycle, host_we is forwarded with 1-cycle latency (bus at t+1).
  - If the sequencer drives the bus in a cycle, a simultaneous host write goes into the one-entry buffer.
  - Host write while the buffer is full: the write is discarded and host_drop is set.
  - A buffered write is also drained in any non-WRITE cycle in which bus_we would otherwise be 0. In FLUSH, a new host write arriving the same cycle refills the freed buffer.
- Preset table N=5 entries, order: luma delay 0x0000, U delay 0x000C, V delay 0x000D, chroma ctrl 0x0006, black level 0x0009.
  - PAL: 0, 0, 0, 0x12, 52.
  - NTSC: 0, 0, 0, 0x12, 56.
  - SECAM: 4, 0, 0, 0x10, 52.

Optional Feature:
- Macro: VIDEO_MODE_SEQ_SCALER_EN.
- Defined:
  - N=8; three extra writes appended after black level.
  - Addresses: Y scaler 0x0200|idx, U scaler 0x0204|idx, V scaler 0x0208|idx, with idx PAL=0, NTSC=1, SECAM=2.
  - Values: Y=142 for all standards; U and V = 15 for PAL/NTSC, 35 for SECAM.
- Undefined: N=5, no scaler writes.

Decomposition:
- Package common:
  - preset_entry_t struct (addr 16, data 8).
  - Preset value constants and N.
  - std_index function mapping video_standard_e to 0..2.
- Sub-module vms_host_buffer: one-entry write buffer with full flag, drop detection and a drain handshake.

Test Plan:
- Reset release → PAL preset written starting 1 cycle after reset drops. Bus shows (0x0000,0), (0x000C,0), (0x000D,0), (0x0006,0x12), (0x0009,52). Then done=1, busy=0.
- req NTSC then newframe at cycle T → writes at T+2..T+6, last is (0x0009,56). done at T+7; video_standard=NTSC in the same cycle; secam_enabled=0.
- req SECAM → after commit secam_enabled=1; luma delay write carries 4; with VIDEO_MODE_SEQ_SCALER_EN, (0x020A,35) is the final write.
- host_we (0x0007,0x2A) in the same cycle as preset write 2 → buffered, emitted in FLUSH before done; host_drop stays 0.
- Two host writes during a busy WRITE burst (SEQ_GAP=0) → the second is dropped, host_drop=1 until reset.
- req PAL while already PAL → no bus_we, no done. Reset asserted during WRITE index 3 → bus_we=0 next cycle, BOOT restarts the PAL preset.

Source files
------------

// File: rtl/video_mode_sequencer_pkg.sv
// rtl/video_mode_sequencer_pkg.sv - shared types, preset table and helpers (VIDEO_MODE_SEQ_SCALER_EN adds scaler presets)
package video_mode_sequencer_pkg;

    typedef enum logic [1:0] {
        PAL   = 2'd0,
        NTSC  = 2'd1,
        SECAM = 2'd2
    } video_standard_e;

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        WAIT_FRAME,
        WRITE,
        FLUSH,
        COMMIT
    } seq_state_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } preset_entry_t;

`ifdef VIDEO_MODE_SEQ_SCALER_EN
    localparam int PRESET_N = 8;
    localparam logic [15:0] ADDR_Y_SCALER = 16'h0200;
    localparam logic [15:0] ADDR_U_SCALER = 16'h0204;
    localparam logic [15:0] ADDR_V_SCALER = 16'h0208;
    localparam logic [7:0]  SCALER_Y           = 8'd142;
    localparam logic [7:0]  SCALER_UV_PAL_NTSC = 8'd15;
    localparam logic [7:0]  SCALER_UV_SECAM    = 8'd35;
`else
    localparam int PRESET_N = 5;
`endif
    localparam int IDX_W = 3;

    localparam logic [15:0] ADDR_LUMA_DELAY  = 16'h0000;
    localparam logic [15:0] ADDR_U_DELAY     = 16'h000C;
    localparam logic [15:0] ADDR_V_DELAY     = 16'h000D;
    localparam logic [15:0] ADDR_CHROMA_CTRL = 16'h0006;
    localparam logic [15:0] ADDR_BLACK_LEVEL = 16'h0009;

    localparam logic [7:0] LUMA_DELAY_SECAM     = 8'd4;
    localparam logic [7:0] CHROMA_CTRL_PAL_NTSC = 8'h12;
    localparam logic [7:0] CHROMA_CTRL_SECAM    = 8'h10;
    localparam logic [7:0] BLACK_PAL_SECAM      = 8'd52;
    localparam logic [7:0] BLACK_NTSC           = 8'd56;

    function automatic logic [1:0] std_index(input video_standard_e s);
        case (s)
            NTSC:    return 2'd1;
            SECAM:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic preset_entry_t preset_entry(input video_standard_e s,
                                                   input logic [IDX_W-1:0] idx);
        preset_entry_t e;
        e.addr = 16'h0000;
        e.data = 8'h00;
        case (idx)
            3'd0: begin
                e.addr = ADDR_LUMA_DELAY;
                e.data = (s == SECAM) ? LUMA_DELAY_SECAM : 8'd0;
            end
            3'd1: e.addr = ADDR_U_DELAY;
            3'd2: e.addr = ADDR_V_DELAY;
            3'd3: begin
                e.addr = ADDR_CHROMA_CTRL;
                e.data = (s == SECAM) ? CHROMA_CTRL_SECAM : CHROMA_CTRL_PAL_NTSC;
            end
            3'd4: begin
                e.addr = ADDR_BLACK_LEVEL;
                e.data = (s == NTSC) ? BLACK_NTSC : BLACK_PAL_SECAM;
            end
`ifdef VIDEO_MODE_SEQ_SCALER_EN
            3'd5: begin
                e.addr = ADDR_Y_SCALER | {14'd0, std_index(s)};
                e.data = SCALER_Y;
            end
            3'd6: begin
                e.addr = ADDR_U_SCALER | {14'd0, std_index(s)};
                e.data = (s == SECAM) ? SCALER_UV_SECAM : SCALER_UV_PAL_NTSC;
            end
            3'd7: begin
                e.addr = ADDR_V_SCALER | {14'd0, std_index(s)};
                e.data = (s == SECAM) ? SCALER_UV_SECAM : SCALER_UV_PAL_NTSC;
            end
`endif
            default: ;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/vms_host_buffer.sv
// rtl/vms_host_buffer.sv - one-entry host write buffer with drain handshake and sticky drop flag
module vms_host_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic [15:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        drain,
    output logic        full,
    output logic [15:0] addr,
    output logic [7:0]  data,
    output logic        drop
);

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            addr <= 16'h0000;
            data <= 8'h00;
            drop <= 1'b0;
        end else begin
            // A drain in the same cycle frees the slot, so the new write refills it.
            if (wr && (!full || drain)) begin
                full <= 1'b1;
                addr <= wr_addr;
                data <= wr_data;
            end else if (drain) begin
                full <= 1'b0;
            end
            if (wr && full && !drain) begin
                drop <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/video_mode_sequencer.sv
// rtl/video_mode_sequencer.sv - frame-aligned preset replay and standard commit for the encoder (VIDEO_MODE_SEQ_SCALER_EN)
module video_mode_sequencer
    import video_mode_sequencer_pkg::*;
#(
    parameter int SEQ_GAP = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            newframe,
    input  logic            req_valid,
    input  video_standard_e req_standard,
    input  logic [15:0]     host_addr,
    input  logic [7:0]      host_wdata,
    input  logic            host_we,
    output logic [15:0]     bus_addr,
    output logic [7:0]      bus_wdata,
    output logic            bus_we,
    output video_standard_e video_standard,
    output logic            secam_enabled,
    output logic            busy,
    output logic            done,
    output logic            host_drop
);

    localparam int GAP_W = (SEQ_GAP > 0) ? $clog2(SEQ_GAP + 1) : 1;

    seq_state_e         state, state_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [GAP_W-1:0]   gap_cnt, gap_d;
    video_standard_e    target, target_d, pend_std, pend_std_d, std_d, cand_std;
    logic               pend_valid, pend_valid_d, cand_valid;
    logic               we_d, secam_d, done_d;
    logic [15:0]        addr_d;
    logic [7:0]         wdata_d;
    logic               buf_wr, buf_drain, buf_full;
    logic [15:0]        buf_addr;
    logic [7:0]         buf_data;
    preset_entry_t      entry;
    logic               write_phase, seq_emit, last_entry;

    vms_host_buffer u_host_buffer (
        .clk     (clk),
        .reset   (reset),
        .wr      (buf_wr),
        .wr_addr (host_addr),
        .wr_data (host_wdata),
        .drain   (buf_drain),
        .full    (buf_full),
        .addr    (buf_addr),
        .data    (buf_data),
        .drop    (host_drop)
    );

    assign entry       = preset_entry(target, idx);
    assign write_phase = (state == BOOT) || (state == WRITE);
    assign seq_emit    = write_phase && (gap_cnt == '0);
    assign last_entry  = (idx == IDX_W'(PRESET_N - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= BOOT;
            idx            <= '0;
            gap_cnt        <= '0;
            target         <= PAL;
            pend_valid     <= 1'b0;
            pend_std       <= PAL;
            bus_we         <= 1'b0;
            bus_addr       <= 16'h0000;
            bus_wdata      <= 8'h00;
            video_standard <= PAL;
            secam_enabled  <= 1'b0;
            busy           <= 1'b1;
            done           <= 1'b0;
        end else begin
            state          <= state_d;
            idx            <= idx_d;
            gap_cnt        <= gap_d;
            target         <= target_d;
            pend_valid     <= pend_valid_d;
            pend_std       <= pend_std_d;
            bus_we         <= we_d;
            bus_addr       <= addr_d;
            bus_wdata      <= wdata_d;
            video_standard <= std_d;
            secam_enabled  <= secam_d;
            busy           <= (state_d != IDLE);
            done           <= done_d;
        end
    end

    always_comb begin
        state_d      = state;
        idx_d        = idx;
        gap_d        = gap_cnt;
        target_d     = target;
        pend_valid_d = pend_valid;
        pend_std_d   = pend_std;
        we_d         = 1'b0;
        addr_d       = bus_addr;
        wdata_d      = bus_wdata;
        std_d        = video_standard;
        secam_d      = secam_enabled;
        done_d       = 1'b0;
        buf_wr       = 1'b0;
        buf_drain    = 1'b0;
        cand_valid   = 1'b0;
        cand_std     = pend_std;

        // Bus priority: preset entry, then buffered host write, then live host write.
        if (seq_emit) begin
            we_d    = 1'b1;
            addr_d  = entry.addr;
            wdata_d = entry.data;
            buf_wr  = host_we;
        end else if (buf_full && !write_phase) begin
            we_d      = 1'b1;
            addr_d    = buf_addr;
            wdata_d   = buf_data;
            buf_drain = 1'b1;
            buf_wr    = host_we;
        end else if (host_we) begin
            we_d    = 1'b1;
            addr_d  = host_addr;
            wdata_d = host_wdata;
        end

        if (req_valid && state != IDLE && state != WAIT_FRAME) begin
            pend_valid_d = 1'b1;
            pend_std_d   = req_standard;
        end

        case (state)
            BOOT, WRITE: begin
                if (seq_emit) begin
                    if (last_entry) begin
                        idx_d   = '0;
                        state_d = (buf_full || buf_wr) ? FLUSH : COMMIT;
                    end else begin
                        idx_d   = idx + IDX_W'(1);
                        gap_d   = GAP_W'(SEQ_GAP);
                        state_d = WRITE;
                    end
                end else begin
                    gap_d = gap_cnt - GAP_W'(1);
                end
            end
            IDLE: begin
                pend_valid_d = 1'b0;
                if (req_valid) begin
                    cand_valid = 1'b1;
                    cand_std   = req_standard;
                end else if (pend_valid) begin
                    cand_valid = 1'b1;
                    cand_std   = pend_std;
                end
                if (cand_valid && cand_std != video_standard) begin
                    target_d = cand_std;
                    state_d  = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (req_valid) begin
                    target_d = req_standard;
                end
                if (newframe) begin
                    state_d = WRITE;
                    idx_d   = '0;
                    gap_d   = '0;
                end
            end
            FLUSH: begin
                state_d = COMMIT;
            end
            COMMIT: begin
                std_d   = target;
                secam_d = (target == SECAM);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

endmodule
